// File: rtl/lh_sweep_collector.sv
// Lighthouse sweep collector: assembles axis 0..3 measurements into frames and queues them.
// Optional LH_RANGE_CHECK_EN rejects measurements outside [MIN_TICKS, MAX_TICKS].
module lh_sweep_collector #(
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int MIN_TICKS      = 150000,
    parameter int MAX_TICKS      = 260000
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [DATA_W-1:0]   MEAS_DATA,
    input  logic [1:0]          MEAS_ADDR,
    input  logic                MEAS_READY,
    output logic [4*DATA_W-1:0] FRAME_DATA,
    output logic [7:0]          FRAME_SEQ,
    output logic                FRAME_VALID,
    input  logic                FRAME_READY,
    output logic [7:0]          ERR_COUNT,
    output logic [7:0]          OVF_COUNT
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          expect_q, expect_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [DATA_W-1:0]   axes_q [4];
    logic [DATA_W-1:0]   axes_d [4];
    logic                prev_q;
    logic [7:0]          seq_q, err_q, ovf_q;
    logic [4*DATA_W-1:0] buf_data_q [2];
    logic [7:0]          buf_seq_q [2];
    logic                head_q;
    logic [1:0]          count_q;

    logic accept, range_ok, err_evt, push;
    logic do_pop, do_wr, drop, wr_idx;

    assign accept = MEAS_READY && !prev_q;

`ifdef LH_RANGE_CHECK_EN
    assign range_ok = (MEAS_DATA >= DATA_W'(MIN_TICKS)) &&
                      (MEAS_DATA <= DATA_W'(MAX_TICKS));
`else
    assign range_ok = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        expect_d = expect_q;
        timer_d  = timer_q;
        axes_d   = axes_q;
        err_evt  = 1'b0;
        push     = 1'b0;
        if (accept) begin
            if (!range_ok) begin
                err_evt = 1'b1;
                state_d = IDLE;
            end else if (state_q == IDLE || MEAS_ADDR != expect_q) begin
                // Out-of-sequence axis 0 restarts a frame instead of idling
                err_evt = (state_q == COLLECT) || (MEAS_ADDR != 2'd0);
                if (MEAS_ADDR == 2'd0) begin
                    axes_d[0] = MEAS_DATA;
                    expect_d  = 2'd1;
                    timer_d   = '0;
                    state_d   = COLLECT;
                end else begin
                    state_d = IDLE;
                end
            end else begin
                axes_d[MEAS_ADDR] = MEAS_DATA;
                expect_d = expect_q + 2'd1;
                timer_d  = '0;
                if (MEAS_ADDR == 2'd3) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end
            end
        end else if (state_q == COLLECT) begin
            if (timer_q == TW'(TIMEOUT_CYCLES)) begin
                err_evt = 1'b1;
                state_d = IDLE;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end
    end

    // Same-cycle pop frees the head slot, which is exactly where a full-buffer push lands
    assign do_pop = (count_q != 2'd0) && FRAME_READY;
    assign drop   = push && (count_q == 2'd2) && !do_pop;
    assign do_wr  = push && !drop;
    assign wr_idx = head_q ^ count_q[0];

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            expect_q <= '0;
            timer_q  <= '0;
            for (int i = 0; i < 4; i++) axes_q[i] <= '0;
            prev_q   <= 1'b1;
            seq_q    <= '0;
            err_q    <= '0;
            ovf_q    <= '0;
            for (int i = 0; i < 2; i++) begin
                buf_data_q[i] <= '0;
                buf_seq_q[i]  <= '0;
            end
            head_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            expect_q <= expect_d;
            timer_q  <= timer_d;
            axes_q   <= axes_d;
            prev_q   <= MEAS_READY;
            if (push) seq_q <= seq_q + 8'd1;
            if (err_evt && err_q != 8'hFF) err_q <= err_q + 8'd1;
            if (drop && ovf_q != 8'hFF) ovf_q <= ovf_q + 8'd1;
            if (do_wr) begin
                buf_data_q[wr_idx] <= {MEAS_DATA, axes_q[2], axes_q[1], axes_q[0]};
                buf_seq_q[wr_idx]  <= seq_q;
            end
            if (do_pop) head_q <= ~head_q;
            count_q <= count_q + {1'b0, do_wr} - {1'b0, do_pop};
        end
    end

    assign FRAME_DATA  = buf_data_q[head_q];
    assign FRAME_SEQ   = buf_seq_q[head_q];
    assign FRAME_VALID = (count_q != 2'd0);
    assign ERR_COUNT   = err_q;
    assign OVF_COUNT   = ovf_q;

endmodule

// File: tb/tb_lh_sweep_collector.sv
// Directed bench for lh_sweep_collector; short timeout keeps the run small.
// Build with LH_RANGE_CHECK_EN to exercise the range-check variant.
module tb_lh_sweep_collector;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  meas_data;
    logic [1:0]   meas_addr;
    logic         meas_ready;
    logic [127:0] frame_data;
    logic [7:0]   frame_seq;
    logic         frame_valid;
    logic         frame_ready;
    logic [7:0]   err_count;
    logic [7:0]   ovf_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]   pop_seq  [$];
    logic [127:0] pop_data [$];

    lh_sweep_collector #(
        .DATA_W        (32),
        .TIMEOUT_CYCLES(50),
        .MIN_TICKS     (150000),
        .MAX_TICKS     (260000)
    ) dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .MEAS_DATA  (meas_data),
        .MEAS_ADDR  (meas_addr),
        .MEAS_READY (meas_ready),
        .FRAME_DATA (frame_data),
        .FRAME_SEQ  (frame_seq),
        .FRAME_VALID(frame_valid),
        .FRAME_READY(frame_ready),
        .ERR_COUNT  (err_count),
        .OVF_COUNT  (ovf_count)
    );

    always #5 clk = ~clk;

    // A handshake seen between edges completes at the next rising edge
    always @(negedge clk) begin
        if (rst_n && frame_valid && frame_ready) begin
            pop_seq.push_back(frame_seq);
            pop_data.push_back(frame_data);
        end
    end

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] fr(input logic [31:0] a0, a1, a2, a3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit rdy);
        @(posedge clk); #1;
        rst_n       = 1'b0;
        meas_ready  = 1'b0;
        frame_ready = rdy;
        idle(2);
        rst_n = 1'b1;
        pop_seq.delete();
        pop_data.delete();
    endtask

    task automatic meas(input logic [1:0] a, input logic [31:0] d,
                        input bit pop = 1'b0);
        @(posedge clk); #1;
        meas_addr  = a;
        meas_data  = d;
        meas_ready = 1'b1;
        if (pop) frame_ready = 1'b1;
        @(posedge clk); #1;
        meas_ready = 1'b0;
        if (pop) frame_ready = 1'b0;
    endtask

    task automatic frame4(input logic [31:0] a0, a1, a2, a3);
        meas(2'd0, a0);
        meas(2'd1, a1);
        meas(2'd2, a2);
        meas(2'd3, a3);
    endtask

    initial begin
        rst_n       = 1'b0;
        meas_data   = '0;
        meas_addr   = '0;
        meas_ready  = 1'b0;
        frame_ready = 1'b0;

        // Reset state, with READY held high across release
        @(posedge clk); #1;
        meas_addr  = 2'd1;
        meas_ready = 1'b1;
        idle(2);
        check("rst_valid", frame_valid, 0);
        check("rst_data", frame_data, 0);
        check("rst_seq", frame_seq, 0);
        check("rst_err", err_count, 0);
        check("rst_ovf", ovf_count, 0);
        rst_n = 1'b1;
        idle(3);
        meas_ready = 1'b0;
        idle(2);
        check("ready_high_at_rst", err_count, 0);

        // 1: basic frame
        do_reset(1'b1);
        frame4(209223, 198902, 196984, 193384);
        idle(4);
        check("t1_pops", pop_seq.size(), 1);
        if (pop_seq.size() >= 1) begin
            check("t1_seq", pop_seq[0], 0);
            check("t1_data", pop_data[0], fr(209223, 198902, 196984, 193384));
        end
        check("t1_err", err_count, 0);
        check("t1_valid_gone", frame_valid, 0);

        // 2: 0,1,3 then a good frame
        do_reset(1'b1);
        meas(2'd0, 11); meas(2'd1, 12); meas(2'd3, 13);
        frame4(21, 22, 23, 24);
        idle(4);
        check("t2_err", err_count, 1);
        check("t2_pops", pop_seq.size(), 1);
        if (pop_seq.size() >= 1) begin
            check("t2_seq", pop_seq[0], 0);
            check("t2_data", pop_data[0], fr(21, 22, 23, 24));
        end

        // 3: timeout mid-frame, then recovery
        do_reset(1'b1);
        meas(2'd0, 31); meas(2'd1, 32);
        idle(60);
        check("t3_err_timeout", err_count, 1);
        check("t3_no_frame", pop_seq.size(), 0);
        frame4(41, 42, 43, 44);
        idle(4);
        check("t3_pops", pop_seq.size(), 1);
        if (pop_seq.size() >= 1)
            check("t3_data", pop_data[0], fr(41, 42, 43, 44));
        check("t3_err_after", err_count, 1);

        // 4: overflow with consumer stalled
        do_reset(1'b0);
        frame4(100, 101, 102, 103);
        frame4(200, 201, 202, 203);
        frame4(300, 301, 302, 303);
        idle(3);
        check("t4_valid", frame_valid, 1);
        check("t4_head_seq", frame_seq, 0);
        check("t4_head_data", frame_data, fr(100, 101, 102, 103));
        check("t4_ovf", ovf_count, 1);
        frame_ready = 1'b1;
        idle(5);
        check("t4_pops", pop_seq.size(), 2);
        if (pop_seq.size() == 2) begin
            check("t4_pop0", pop_seq[0], 0);
            check("t4_pop1", pop_seq[1], 1);
            check("t4_pop1_data", pop_data[1], fr(200, 201, 202, 203));
        end

        // 5: full buffer, push and pop on the same edge
        do_reset(1'b0);
        frame4(500, 501, 502, 503);
        frame4(600, 601, 602, 603);
        meas(2'd0, 700); meas(2'd1, 701); meas(2'd2, 702);
        meas(2'd3, 703, 1'b1);
        idle(2);
        check("t5_ovf", ovf_count, 0);
        check("t5_head_seq", frame_seq, 1);
        check("t5_one_pop", pop_seq.size(), 1);
        frame_ready = 1'b1;
        idle(5);
        check("t5_pops", pop_seq.size(), 3);
        if (pop_seq.size() == 3) begin
            check("t5_pop2_seq", pop_seq[2], 2);
            check("t5_pop2_data", pop_data[2], fr(700, 701, 702, 703));
        end
        check("t5_ovf_end", ovf_count, 0);

        // 6: out-of-range axis1
        do_reset(1'b1);
        frame4(200000, 100000, 200000, 200000);
        idle(4);
`ifdef LH_RANGE_CHECK_EN
        check("t6_err", err_count, 3);
        check("t6_pops", pop_seq.size(), 0);
`else
        check("t6_err", err_count, 0);
        check("t6_pops", pop_seq.size(), 1);
        if (pop_seq.size() >= 1)
            check("t6_data", pop_data[0], fr(200000, 100000, 200000, 200000));
`endif

        // Mid-frame reset
        do_reset(1'b1);
        frame4(1, 2, 3, 4);
        meas(2'd2, 9);
        meas(2'd0, 5); meas(2'd1, 6); meas(2'd2, 7);
        check("pre_rst_err", err_count, 1);
        do_reset(1'b1);
        check("mrst_err", err_count, 0);
        check("mrst_valid", frame_valid, 0);
        check("mrst_data", frame_data, 0);
        meas(2'd3, 8);
        idle(3);
        check("mrst_err_addr3", err_count, 1);
        check("mrst_no_frame", pop_seq.size(), 0);
        frame4(51, 52, 53, 54);
        idle(3);
        check("mrst_pops", pop_seq.size(), 1);
        if (pop_seq.size() >= 1)
            check("mrst_seq", pop_seq[0], 0);

        // ERR counter saturation
        do_reset(1'b1);
        for (int i = 0; i < 260; i++) meas(2'd1, 0);
        idle(2);
        check("err_sat", err_count, 255);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
